// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - decoder issue port and memory-controller refill port of the fetch stage
interface inst_fetcher_if;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_jump;
  logic        mc_en;
  logic [31:0] mc_pc;
  logic        mc_done;
  logic [31:0] mc_data;

  modport master (
    output inst_rdy, inst, inst_pc, inst_pred_jump, mc_en, mc_pc,
    input  mc_done, mc_data
  );

  modport slave (
    input  inst_rdy, inst, inst_pc, inst_pred_jump, mc_en, mc_pc,
    output mc_done, mc_data
  );
endinterface

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - fetch PC, one-word-per-line icache, bimodal/JAL next-PC prediction
module inst_fetcher #(
  parameter int ICACHE_IDX_W = 8,
  parameter int BHT_IDX_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rob_full,
  input  logic        br_en,
  input  logic [31:0] br_pc,
  input  logic        br_jumped,
  inst_fetcher_if.master fif
);
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic {IDLE, WAIT_MEM} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               pc_q, pc_d;
  logic                      inst_rdy_q, inst_rdy_d;
  logic [31:0]               inst_q, inst_d;
  logic [31:0]               inst_pc_q, inst_pc_d;
  logic                      pred_q, pred_d;
  logic                      mc_en_q, mc_en_d;
  logic [31:0]               mc_pc_q, mc_pc_d;
  logic [LINES-1:0]          valid_q, valid_d;
  logic [TAG_W-1:0]          tag_q [LINES];
  logic [TAG_W-1:0]          tag_d [LINES];
  logic [31:0]               data_q [LINES];
  logic [31:0]               data_d [LINES];
  logic [1:0]                bht_q [BHT_N];
  logic [1:0]                bht_d [BHT_N];

  logic [ICACHE_IDX_W-1:0]   idx, wr_idx;
  logic [BHT_IDX_W-1:0]      bht_idx, br_idx;
  logic [TAG_W-1:0]          pc_tag;
  logic [31:0]               word, imm_j, imm_b, next_pc;
  logic                      hit, stall, issue, pred_taken;
  logic [1:0]                ctr;
  logic                      br_pc_unused;

  assign idx          = pc_q[ICACHE_IDX_W+1:2];
  assign pc_tag       = pc_q[31:ICACHE_IDX_W+2];
  assign bht_idx      = pc_q[BHT_IDX_W+1:2];
  assign wr_idx       = mc_pc_q[ICACHE_IDX_W+1:2];
  assign br_idx       = br_pc[BHT_IDX_W+1:2];
  assign br_pc_unused = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0]};
  assign hit          = valid_q[idx] && (tag_q[idx] == pc_tag);
  assign word         = data_q[idx];
  assign stall        = rs_full | lsb_full | rob_full;
  assign issue        = (state_q == IDLE) && !rollback && !stall && hit;
  assign imm_j        = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
  assign imm_b        = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};

  // BHT read is the registered value, so a same-cycle commit update is not seen here.
  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc_q + 32'd4;
    if (word[6:0] == 7'b1101111) begin
      pred_taken = 1'b1;
      next_pc    = pc_q + imm_j;
    end else if (word[6:0] == 7'b1100011 && bht_q[bht_idx][1]) begin
      pred_taken = 1'b1;
      next_pc    = pc_q + imm_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rdy) begin
      case (state_q)
        IDLE:     if (!rollback && !hit) state_d = WAIT_MEM;
        WAIT_MEM: if (fif.mc_done) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    inst_rdy_d = 1'b0;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    pred_d     = pred_q;
    mc_en_d    = mc_en_q;
    mc_pc_d    = mc_pc_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    bht_d      = bht_q;
    ctr        = bht_q[br_idx];
    if (rdy) begin
      if (rollback) begin
        pc_d = rollback_pc;
      end else if (issue) begin
        pc_d = next_pc;
      end
      if (issue) begin
        inst_rdy_d = 1'b1;
        inst_d     = word;
        inst_pc_d  = pc_q;
        pred_d     = pred_taken;
      end
      if (state_q == IDLE && !rollback && !hit) begin
        mc_en_d = 1'b1;
        mc_pc_d = {pc_q[31:2], 2'b00};
      end
      // A refill always lands in its own line, even if a rollback moved pc away meanwhile.
      if (state_q == WAIT_MEM && fif.mc_done) begin
        mc_en_d         = 1'b0;
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = mc_pc_q[31:ICACHE_IDX_W+2];
        data_d[wr_idx]  = fif.mc_data;
      end
      if (br_en) begin
        if (br_jumped && ctr != 2'b11) begin
          bht_d[br_idx] = ctr + 2'b01;
        end else if (!br_jumped && ctr != 2'b00) begin
          bht_d[br_idx] = ctr - 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      inst_rdy_q <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      pred_q     <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_pc_q    <= '0;
      valid_q    <= '0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q       <= pc_d;
      inst_rdy_q <= inst_rdy_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      pred_q     <= pred_d;
      mc_en_q    <= mc_en_d;
      mc_pc_q    <= mc_pc_d;
      valid_q    <= valid_d;
      bht_q      <= bht_d;
    end
  end

  // Tag and data need no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign fif.inst_rdy       = inst_rdy_q;
  assign fif.inst           = inst_q;
  assign fif.inst_pc        = inst_pc_q;
  assign fif.inst_pred_jump = pred_q;
  assign fif.mc_en          = mc_en_q;
  assign fif.mc_pc          = mc_pc_q;
endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed scoreboard bench for inst_fetcher
module tb_inst_fetcher;
  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] JAL12 = 32'h00C0006F;
  localparam logic [31:0] JAL8  = 32'h0080006F;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] BEQ   = 32'hFE000EE3;
  localparam logic [31:0] W40   = 32'h00700113;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } issue_t;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, rs_full, lsb_full, rob_full, br_en, br_jumped;
  logic [31:0] rollback_pc, br_pc;
  int          n_cmp = 0;
  int          n_err = 0;
  issue_t      exp_q[$];

  inst_fetcher_if fif ();

  inst_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rollback   (rollback),
    .rollback_pc(rollback_pc),
    .rs_full    (rs_full),
    .lsb_full   (lsb_full),
    .rob_full   (rob_full),
    .br_en      (br_en),
    .br_pc      (br_pc),
    .br_jumped  (br_jumped),
    .fif        (fif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
    issue_t e;
    e.pc = pc; e.inst = inst; e.pred = pred;
    exp_q.push_back(e);
  endtask

  task automatic wait_mc(input logic [31:0] addr);
    int n = 0;
    while (fif.mc_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("mc_en_req", {31'd0, fif.mc_en}, 32'd1);
    chk("mc_pc_req", fif.mc_pc, addr);
  endtask

  task automatic mc_finish(input logic [31:0] data);
    fif.mc_done = 1'b1;
    fif.mc_data = data;
    tick();
    fif.mc_done = 1'b0;
    fif.mc_data = '0;
    chk("gap_after_fill", {31'd0, fif.inst_rdy}, 32'd0);
  endtask

  task automatic serve_issue(input logic [31:0] addr, input logic [31:0] data, input logic pred);
    wait_mc(addr);
    push(addr, data, pred);
    mc_finish(data);
  endtask

  task automatic redirect(input logic [31:0] addr);
    rollback    = 1'b1;
    rollback_pc = addr;
    tick();
    rollback    = 1'b0;
  endtask

  task automatic release1();
    rob_full = 1'b0;
    tick();
    rob_full = 1'b1;
  endtask

  always @(negedge clk) begin
    if (fif.inst_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("issue_expected", 32'd0, 32'd1);
      end else begin
        issue_t e;
        e = exp_q.pop_front();
        chk("inst_pc", fif.inst_pc, e.pc);
        chk("inst", fif.inst, e.inst);
        chk("inst_pred_jump", {31'd0, fif.inst_pred_jump}, {31'd0, e.pred});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = '0;
    rs_full = 1'b0; lsb_full = 1'b0; rob_full = 1'b0;
    br_en = 1'b0; br_pc = '0; br_jumped = 1'b0;
    fif.mc_done = 1'b0; fif.mc_data = '0;
    tick(); tick();
    chk("rst_inst_rdy", {31'd0, fif.inst_rdy}, 32'd0);
    chk("rst_inst", fif.inst, 32'd0);
    chk("rst_inst_pc", fif.inst_pc, 32'd0);
    chk("rst_pred", {31'd0, fif.inst_pred_jump}, 32'd0);
    chk("rst_mc_en", {31'd0, fif.mc_en}, 32'd0);
    chk("rst_mc_pc", fif.mc_pc, 32'd0);
    rst = 1'b0;

    serve_issue(32'h00, ADDI, 1'b0);
    serve_issue(32'h04, JAL12, 1'b1);
    serve_issue(32'h10, JAL8, 1'b1);
    serve_issue(32'h18, NOP, 1'b0);
    serve_issue(32'h1C, NOP, 1'b0);
    serve_issue(32'h20, BEQ, 1'b0);
    wait_mc(32'h24);

    // Redirect to the branch while 0x24 is in flight; three taken commits saturate at 3.
    br_en = 1'b1; br_pc = 32'h20; br_jumped = 1'b1;
    redirect(32'h20);
    tick(); tick();
    br_en = 1'b0;
    chk("inflight_mc_en", {31'd0, fif.mc_en}, 32'd1);
    chk("inflight_mc_pc", fif.mc_pc, 32'h24);
    rob_full = 1'b1;
    mc_finish(NOP);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_no_issue", {31'd0, fif.inst_rdy}, 32'd0);
      chk("stall_no_req", {31'd0, fif.mc_en}, 32'd0);
    end
    push(32'h20, BEQ, 1'b1);
    release1();
    tick();
    chk("bt_target_cached", {31'd0, fif.mc_en}, 32'd0);
    push(32'h1C, NOP, 1'b0);
    release1();

    // Rollback while waiting on 0x40 must not cancel that refill.
    redirect(32'h40);
    wait_mc(32'h40);
    redirect(32'h100);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rb_hold_mc_en", {31'd0, fif.mc_en}, 32'd1);
      chk("rb_hold_mc_pc", fif.mc_pc, 32'h40);
    end
    rob_full = 1'b0;
    mc_finish(W40);
    serve_issue(32'h100, NOP, 1'b0);
    wait_mc(32'h104);
    rob_full = 1'b1;
    redirect(32'h40);
    mc_finish(NOP);
    tick(); tick();
    chk("line40_valid", {31'd0, fif.mc_en}, 32'd0);
    push(32'h40, W40, 1'b0);
    release1();
    wait_mc(32'h44);

    // rdy low: rollback, stall release and not-taken commits are all ignored.
    rdy = 1'b0; rollback = 1'b1; rollback_pc = 32'h20;
    br_en = 1'b1; br_pc = 32'h20; br_jumped = 1'b0; rob_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy0_inst_rdy", {31'd0, fif.inst_rdy}, 32'd0);
      chk("rdy0_mc_en", {31'd0, fif.mc_en}, 32'd1);
      chk("rdy0_mc_pc", fif.mc_pc, 32'h44);
    end
    rdy = 1'b1; rollback = 1'b0; br_en = 1'b0; rob_full = 1'b1;
    mc_finish(NOP);
    redirect(32'h20);
    push(32'h20, BEQ, 1'b1);
    release1();
    br_en = 1'b1; br_pc = 32'h20; br_jumped = 1'b0;
    tick(); tick();
    br_en = 1'b0;
    push(32'h1C, NOP, 1'b0);
    release1();
    // Counter is 01 here; the same-cycle taken commit must not affect this lookup.
    push(32'h20, BEQ, 1'b0);
    br_en = 1'b1; br_jumped = 1'b1;
    release1();
    br_en = 1'b0;
    push(32'h24, NOP, 1'b0);
    release1();
    rob_full = 1'b0;
    wait_mc(32'h28);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_mc_en", {31'd0, fif.mc_en}, 32'd0);
    chk("midrst_mc_pc", fif.mc_pc, 32'd0);
    chk("midrst_inst_rdy", {31'd0, fif.inst_rdy}, 32'd0);
    chk("midrst_inst", fif.inst, 32'd0);
    serve_issue(32'h00, ADDI, 1'b0);
    wait_mc(32'h04);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Holds the architectural fetch PC and a direct-mapped instruction cache with one word per line.
- Predicts the next PC using a 2-bit bimodal BHT plus JAL target decode.
- Hands one instruction per cycle to the decoder as a registered single-cycle pulse; refills misses through the memory controller.

Parameters:
- ICACHE_IDX_W, 8, log2 of icache lines; a line is one 32-bit word, index is pc[ICACHE_IDX_W+1:2].
- BHT_IDX_W, 8, log2 of BHT entries, index is pc[BHT_IDX_W+1:2].

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  misprediction flush from the ROB.
- rollback_pc  in  32  correct PC to resume at.
- rs_full  in  1  reservation station cannot take an instruction next cycle.
- lsb_full  in  1  load/store buffer cannot take an instruction next cycle.
- rob_full  in  1  ROB cannot take an instruction next cycle.
- inst_rdy  out  1  instruction valid this cycle (pulse).
- inst  out  32  instruction word.
- inst_pc  out  32  its PC.
- inst_pred_jump  out  1  predicted taken.
- mc_en  out  1  memory fetch request, held high until mc_done.
- mc_pc  out  32  word-aligned fetch address.
- mc_done  in  1  fetch complete (1-cycle pulse).
- mc_data  in  32  fetched word, valid with mc_done.
- br_en  in  1  branch commit update from the ROB.
- br_pc  in  32  PC of the committed branch.
- br_jumped  in  1  actual outcome of the committed branch.

Behaviour:
- Reset (rst=1 at a posedge, highest priority; aborts any refill):
  - pc=0, state=IDLE.
  - inst_rdy=0, inst=0, inst_pc=0, inst_pred_jump=0.
  - mc_en=0, mc_pc=0.
  - All icache valid bits cleared; all BHT counters set to 2'b01 (weakly not-taken).
- rdy=0: no register, cache or BHT changes. Outputs hold, except that inst_rdy is forced to 0.
- Stall condition: stall = rs_full | lsb_full | rob_full.
- Hit lookup: combinational on pc. Hit = valid[idx] && tag[idx]==pc[31:ICACHE_IDX_W+2].
- Issue (state IDLE, !rollback, !stall, hit) — at the next posedge:
  - inst_rdy=1, inst=data[idx], inst_pc=pc.
  - pc updated to the predicted next PC.
  - Issue latency: 1 cycle from hit to inst_rdy.
- Otherwise inst_rdy=0 at the next posedge.
- Prediction, decoded from the cached word w:
  - opcode 1101111 (JAL): next = pc + sext({w[31],w[19:12],w[20],w[30:21],0}); pred=1.
  - opcode 1100011 (BR): taken = bht[pc idx][1]. If taken, next = pc + sext({w[31],w[7],w[30:25],w[11:8],0}); otherwise pc+4. pred=taken.
  - All other opcodes, including JALR: next = pc+4; pred=0.
  - All additions are 32-bit and wrap modulo 2^32.
- Miss handling, 2-state FSM:
  - IDLE → WAIT_MEM when !hit and !rollback: mc_en=1, mc_pc={pc[31:2],2'b00}.
  - WAIT_MEM: mc_en and mc_pc are held until mc_done.
  - On mc_done: write data/tag/valid for mc_pc, set mc_en=0, return to IDLE.
  - The refilled instruction issues no earlier than the cycle after the return to IDLE.
  - The miss is handled regardless of stall; refill proceeds while stalled.
- Rollback (rdy=1, rollback=1):
  - pc<=rollback_pc; inst_rdy=0 next cycle.
  - Any hit in that cycle is discarded.
  - An in-flight refill is NOT cancelled. It completes and fills the cache line for the old mc_pc, then fetch resumes from rollback_pc.
  - Rollback in the same cycle as mc_done: both take effect.
- BHT update (br_en=1 and rdy=1): saturating counter at br_pc idx; +1 if br_jumped, otherwise −1, saturating at 0 and 3.
  - The update happens in parallel with any lookup.
  - On a same-entry lookup in the same cycle, the lookup uses the pre-update value.
- Simultaneous rollback and stall: rollback wins, pc is redirected.
- Alignment: pc[1:0] is always 0; rollback_pc is assumed aligned by the ROB.

Test Plan:
- Reset, then a miss at pc=0 → mc_en=1, mc_pc=0. mc_done with 0x00500093 (addi) → one cycle with no output. Next: inst_rdy=1, inst=0x00500093, inst_pc=0, pred=0; then pc=4.
- Cached JAL 0x0080006F at pc=0x10 → inst_rdy with pred=1; next fetch pc=0x18.
- Branch 0xFE000EE3 (beq, offset −4) at pc=0x20 with counter=01 → pred=0, next pc=0x24. Two br_en updates with br_jumped=1, then refetch 0x20 → pred=1, next pc=0x1C.
- rob_full=1 while hitting → inst_rdy stays 0 and pc holds. On release, the next cycle issues the same pc.
- Rollback with rollback_pc=0x100 while in WAIT_MEM for 0x40 → mc_en stays high until mc_done, line 0x40 becomes valid, the next request is for 0x100, and no instruction from 0x40 issues.
- rdy=0 for 3 cycles mid-stream → no inst_rdy, pc and BHT unchanged. Assert rst for 1 cycle during WAIT_MEM → mc_en=0, all lines invalid, refetch from 0.
